// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the PC sequencer slice.
package pc_seq_pkg;

  localparam int unsigned DEF_WIDTH        = 16;
  localparam int unsigned DEF_RAS_DEPTH    = 4;
  localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;
  localparam logic [15:0] DEF_IRQ_VECTOR   = 16'h0004;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_IRQ
  } pc_state_e;

  typedef enum logic [2:0] {
    SRC_INC,
    SRC_BR,
    SRC_CALL,
    SRC_RET,
    SRC_IRQ,
    SRC_HOLD
  } pc_src_e;

endpackage

// File: rtl/pc_seq_ras.sv
// Return-address stack: circular buffer, push-when-full overwrites the oldest entry.
module pc_seq_ras
  import pc_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(RAS_DEPTH - 1);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] top;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;
  logic [CNT_W-1:0] count;

  // top points at the next free slot; once full it also points at the oldest entry
  always_comb begin
    top_inc  = (top == LAST) ? '0 : top + PTR_W'(1);
    top_dec  = (top == '0) ? LAST : top - PTR_W'(1);
    empty    = (count == '0);
    full     = (count == CNT_W'(RAS_DEPTH));
    pop_data = mem[top_dec];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top   <= '0;
      count <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[top] <= push_data;
      top      <= top_inc;
      if (!full) begin
        count <= count + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      top   <= top_dec;
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: increment, branch, call/return, interrupt entry, fetch handshake.
// Build option: define PC_SEQ_RAS_EN to include the return-address stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0]  IRQ_VECTOR   = WIDTH'(DEF_IRQ_VECTOR),
  parameter int unsigned       RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             call_valid,
  input  logic             ret_valid,
  input  logic             irq_req,
  output logic             irq_ack,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             ras_ovf,
  output logic             ras_unf
);

  pc_state_e        state;
  pc_state_e        state_nx;
  pc_src_e          src;
  logic             mask;
  logic             mask_nx;
  logic             adv;
  logic [WIDTH-1:0] pc_inc;

`ifdef PC_SEQ_RAS_EN
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_pop_data;
  logic             ras_empty;
  logic             ras_full;

  pc_seq_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .pop_data  (ras_pop_data),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`endif

  assign pc_inc  = pc + WIDTH'(1);
  assign irq_ack = (state == ST_IRQ);

  // Source select: priority order is IRQ, return, call, branch, increment
  always_comb begin
    src = SRC_HOLD;
    adv = fetch_valid && fetch_ready && !stall && (state != ST_BOOT);
    if (adv) begin
      if (state == ST_RUN && irq_req && !mask) begin
        src = SRC_IRQ;
      end else if (ret_valid) begin
        src = SRC_RET;
      end else if (call_valid) begin
        src = SRC_CALL;
      end else if (br_valid) begin
        src = SRC_BR;
      end else begin
        src = SRC_INC;
      end
    end
  end

  always_comb begin
    pc_next  = pc;
    mask_nx  = mask;
    state_nx = (state == ST_BOOT || state == ST_IRQ) ? ST_RUN : state;
`ifdef PC_SEQ_RAS_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
`endif
    case (src)
      SRC_IRQ: begin
        pc_next  = IRQ_VECTOR;
        mask_nx  = 1'b1;
        state_nx = ST_IRQ;
`ifdef PC_SEQ_RAS_EN
        ras_push = 1'b1;
`endif
      end
      SRC_RET: begin
        mask_nx = 1'b0;
`ifdef PC_SEQ_RAS_EN
        ras_pop = 1'b1;
        pc_next = ras_empty ? pc_inc : ras_pop_data;
`else
        pc_next = pc_inc;
`endif
      end
      SRC_CALL: begin
        pc_next = br_target;
`ifdef PC_SEQ_RAS_EN
        ras_push = 1'b1;
`endif
      end
      SRC_BR:   pc_next = br_target;
      SRC_INC:  pc_next = pc_inc;
      default:  pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      mask        <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_next;
      fetch_valid <= (state_nx != ST_BOOT) && !stall;
      mask        <= mask_nx;
    end
  end

`ifdef PC_SEQ_RAS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      ras_ovf <= ras_ovf | (ras_push & ras_full);
      ras_unf <= ras_unf | (ras_pop & ras_empty);
    end
  end
`else
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed plan steps then random traffic vs a queue-based model.
module tb_pc_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] IRQ_V = 16'h0004;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_valid, call_valid, ret_valid, irq_req, fetch_ready;
  logic [15:0] br_target;
  logic        irq_ack, fetch_valid, ras_ovf, ras_unf;
  logic [15:0] pc, pc_next;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_pc;
  bit          m_fv, m_ack, m_mask, m_ovf, m_unf;
  logic [15:0] m_ras[$];

  pc_sequencer #(
    .WIDTH        (16),
    .RESET_VECTOR (16'h0000),
    .IRQ_VECTOR   (16'h0004),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .call_valid  (call_valid),
    .ret_valid   (ret_valid),
    .irq_req     (irq_req),
    .irq_ack     (irq_ack),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .pc          (pc),
    .pc_next     (pc_next),
    .ras_ovf     (ras_ovf),
    .ras_unf     (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_fv = 0; m_ack = 0; m_mask = 0; m_ovf = 0; m_unf = 0;
    m_ras.delete();
  endtask

  task automatic model_push(input logic [15:0] v);
    if (RAS_ON) begin
      if (m_ras.size() == DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1;
      end
      m_ras.push_back(v);
    end
  endtask

  // Returns the PC expected at the next edge and advances the model by one cycle
  task automatic model_step(output logic [15:0] nxt);
    logic [15:0] inc;
    bit ack;
    inc = m_pc + 16'd1;
    nxt = m_pc;
    ack = 0;
    if (m_fv && fetch_ready && !stall) begin
      if (irq_req && !m_mask) begin
        nxt = IRQ_V; model_push(inc); m_mask = 1; ack = 1;
      end else if (ret_valid) begin
        m_mask = 0;
        nxt = inc;
        if (RAS_ON) begin
          if (m_ras.size() > 0) nxt = m_ras.pop_back();
          else m_unf = 1;
        end
      end else if (call_valid) begin
        nxt = br_target; model_push(inc);
      end else if (br_valid) begin
        nxt = br_target;
      end else begin
        nxt = inc;
      end
    end
    m_fv  = !stall;
    m_ack = ack;
    m_pc  = nxt;
  endtask

  task automatic cyc(input logic fr, input logic st, input logic br, input logic [15:0] tgt,
                     input logic cl, input logic rt, input logic irq);
    logic [15:0] nxt;
    fetch_ready = fr; stall = st; br_valid = br; br_target = tgt;
    call_valid = cl; ret_valid = rt; irq_req = irq;
    @(negedge clk);
    model_step(nxt);
    chk("pc_next", pc_next, nxt);
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("fetch_valid", 16'(fetch_valid), 16'(m_fv));
    chk("irq_ack", 16'(irq_ack), 16'(m_ack));
    chk("ras_ovf", 16'(ras_ovf), 16'(m_ovf));
    chk("ras_unf", 16'(ras_unf), 16'(m_unf));
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 0; br_valid = 0; br_target = '0; call_valid = 0; ret_valid = 0;
    irq_req = 0; fetch_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_pc_next", pc_next, 16'h0000);
    chk("rst_fv", 16'(fetch_valid), 16'h0);
    chk("rst_ack", 16'(irq_ack), 16'h0);
    chk("rst_flags", {14'h0, ras_ovf, ras_unf}, 16'h0);
    rst_n = 1'b1;

    // boot cycle then sequential fetch
    cyc(1, 0, 0, 16'h0, 0, 0, 0);
    chk("first_fetch_pc", pc, 16'h0000);
    chk("first_fetch_fv", 16'(fetch_valid), 16'h1);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 0, 16'h0, 0, 0, 0);
      chk("seq_pc", pc, 16'(i));
    end

    // handshake backpressure, then stall
    repeat (3) cyc(0, 0, 0, 16'h0, 0, 0, 0);
    chk("nready_pc", pc, 16'h0005);
    chk("nready_fv", 16'(fetch_valid), 16'h1);
    repeat (2) begin
      cyc(1, 1, 0, 16'h0, 0, 0, 0);
      chk("stall_fv", 16'(fetch_valid), 16'h0);
      chk("stall_pc", pc, 16'h0005);
    end
    cyc(1, 0, 0, 16'h0, 0, 0, 0);

    // call/return
    cyc(1, 0, 1, 16'h0010, 0, 0, 0);
    cyc(1, 0, 0, 16'h0100, 1, 0, 0);
    chk("call_pc", pc, 16'h0100);
    cyc(1, 0, 0, 16'h0, 0, 0, 0);
    cyc(1, 0, 0, 16'h0, 0, 0, 0);
    cyc(1, 0, 0, 16'h0, 0, 1, 0);
    chk("ret_pc", pc, RAS_ON ? 16'h0011 : 16'h0103);

    // overflow then underflow
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'h0200 + 16'(i * 16), 1, 0, 0);
    chk("ovf_set", 16'(ras_ovf), 16'(RAS_ON));
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'h0, 0, 1, 0);
    chk("unf_pc", pc, RAS_ON ? 16'h0202 : 16'h0245);
    chk("unf_set", 16'(ras_unf), 16'(RAS_ON));

    // interrupt beats branch; masked until return
    cyc(1, 0, 1, 16'h0020, 0, 0, 0);
    cyc(1, 0, 1, 16'h0300, 0, 0, 1);
    chk("irq_pc", pc, 16'h0004);
    chk("irq_ack_pulse", 16'(irq_ack), 16'h1);
    cyc(1, 0, 0, 16'h0, 0, 0, 1);
    chk("irq_ack_drop", 16'(irq_ack), 16'h0);
    cyc(1, 0, 0, 16'h0, 0, 0, 1);
    chk("irq_masked", pc, 16'h0006);
    cyc(1, 0, 0, 16'h0, 0, 1, 1);
    chk("irq_ret_pc", pc, RAS_ON ? 16'h0021 : 16'h0007);
    cyc(1, 0, 0, 16'h0, 0, 0, 1);
    chk("irq_unmasked", pc, 16'h0004);
    cyc(1, 0, 0, 16'h0, 0, 1, 0);

    // wrap
    cyc(1, 0, 1, 16'hFFFF, 0, 0, 0);
    cyc(1, 0, 0, 16'h0, 0, 0, 0);
    chk("wrap_pc", pc, 16'h0000);

    // reset mid-call
    fetch_ready = 1; stall = 0; br_valid = 0; br_target = 16'h0400;
    call_valid = 1; ret_valid = 0; irq_req = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pc", pc, 16'h0000);
    chk("midrst_pc_next", pc_next, 16'h0000);
    chk("midrst_fv", 16'(fetch_valid), 16'h0);
    chk("midrst_ovf", 16'(ras_ovf), 16'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1, 0, 0, 16'h0, 0, 0, 0);
    cyc(1, 0, 0, 16'h0, 0, 1, 0);
    chk("post_rst_ret", pc, 16'h0001);
    chk("post_rst_unf", 16'(ras_unf), 16'(RAS_ON));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
          16'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
